vga_timing_ctrl: RTL and testbench

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

---
 rtl/vga_timing_ctrl_pkg.sv | 53 +++++
 rtl/vga_timing_ctrl_if.sv | 40 ++++
 rtl/vga_timing_ctrl_delay.sv | 33 +++
 rtl/vga_timing_ctrl.sv | 150 +++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_ctrl_pkg.sv
// VGA timing package: default mode constants,
// scan phase encoding and phase-step helper.
package vga_pkg;

  localparam int H_VIS_D = 800;
  localparam int H_FP_D  = 40;
  localparam int H_SW_D  = 128;
  localparam int H_BP_D  = 88;
  localparam int H_TOT_D = H_VIS_D + H_FP_D + H_SW_D + H_BP_D;

  localparam int V_VIS_D = 600;
  localparam int V_FP_D  = 1;
  localparam int V_SW_D  = 4;
  localparam int V_BP_D  = 23;
  localparam int V_TOT_D = V_VIS_D + V_FP_D + V_SW_D + V_BP_D;

  localparam int MODE_PERIOD_D = 60;

  localparam int COL_W = 11;
  localparam int ROW_W = 10;

  typedef enum logic [1:0] {
    PH_VIS,
    PH_FP,
    PH_SYNC,
    PH_BP
  } phase_e;

  function automatic phase_e next_phase(
    input phase_e ph,
    input int     cnt,
    input int     vis,
    input int     fp,
    input int     sw,
    input int     tot
  );
    phase_e nx;
    nx = ph;
    unique case (ph)
      PH_VIS:  if (cnt == vis - 1)
                 nx = PH_FP;
      PH_FP:   if (cnt == vis + fp - 1)
                 nx = PH_SYNC;
      PH_SYNC: if (cnt == vis + fp + sw - 1)
                 nx = PH_BP;
      PH_BP:   if (cnt == tot - 1)
                 nx = PH_VIS;
      default: nx = PH_VIS;
    endcase
    return nx;
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Scan bus between timing controller and
// pattern source / display sink.
interface vga_timing_ctrl_if;
  import vga_pkg::*;

  logic             EN;
  logic             MODE_HOLD;
  logic [7:0]       R_IN;
  logic [7:0]       G_IN;
  logic [7:0]       B_IN;
  logic [COL_W-1:0] COL;
  logic [ROW_W-1:0] ROW;
  logic             HSYNC;
  logic             VSYNC;
  logic             DE;
  logic [7:0]       R;
  logic [7:0]       G;
  logic [7:0]       B;
  logic             FRAME_TICK;
  logic [1:0]       MODE;

  modport master (
    input  EN, MODE_HOLD,
    input  R_IN, G_IN, B_IN,
    output COL, ROW,
    output HSYNC, VSYNC, DE,
    output R, G, B,
    output FRAME_TICK, MODE
  );

  modport slave (
    output EN, MODE_HOLD,
    output R_IN, G_IN, B_IN,
    input  COL, ROW,
    input  HSYNC, VSYNC, DE,
    input  R, G, B,
    input  FRAME_TICK, MODE
  );

endinterface

// File: rtl/vga_timing_ctrl_delay.sv
// Clearable register pipeline used to align
// sync, display enable and colour.
module vga_delay #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_pipe [D];

  // shift one stage per clock; clear empties every stage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < D; i++)
        r_pipe[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < D; i++)
        r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < D; i++)
        r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[D-1];

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: counters, phase FSMs,
// aligned sync/DE/colour, frame tick, mode.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int H_VIS       = H_VIS_D,
  parameter int H_FP        = H_FP_D,
  parameter int H_SW        = H_SW_D,
  parameter int H_BP        = H_BP_D,
  parameter int V_VIS       = V_VIS_D,
  parameter int V_FP        = V_FP_D,
  parameter int V_SW        = V_SW_D,
  parameter int V_BP        = V_BP_D,
  parameter int MODE_PERIOD = MODE_PERIOD_D
) (
  input logic                CLK,
  input logic                RST,
  vga_timing_ctrl_if.master  bus
);

  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;
  localparam int FC_LG = $clog2(MODE_PERIOD + 1);
  localparam int FC_W  = (FC_LG > 6) ? FC_LG : 6;

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_tick;
  logic [FC_W-1:0]  r_fcnt;
  logic [1:0]       r_mode;
  phase_e           r_hph;
  phase_e           r_vph;
  phase_e           w_hph_nxt;
  phase_e           w_vph_nxt;

  logic             w_hwrap;
  logic             w_vwrap;
  logic             w_fwrap;
  logic [2:0]       w_raw;
  logic [2:0]       w_s1;
  logic [26:0]      w_s2_in;
  logic [26:0]      w_s2;

  assign w_hwrap = (r_col == COL_W'(H_TOT - 1));
  assign w_vwrap = (r_row == ROW_W'(V_TOT - 1));
  assign w_fwrap = bus.EN && w_hwrap && w_vwrap;

  // raster counters; tick marks the first pixel after a wrap
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_col  <= '0;
      r_row  <= '0;
      r_tick <= 1'b0;
    end else if (!bus.EN) begin
      r_col  <= '0;
      r_row  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_fwrap;
      if (w_hwrap) begin
        r_col <= '0;
        r_row <= w_vwrap ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // frames-per-mode counter; advances together with the tick
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_fcnt <= '0;
      r_mode <= '0;
    end else if (w_fwrap && !bus.MODE_HOLD) begin
      if (r_fcnt == FC_W'(MODE_PERIOD - 1)) begin
        r_fcnt <= '0;
        r_mode <= r_mode + 2'd1;
      end else begin
        r_fcnt <= r_fcnt + FC_W'(1);
      end
    end
  end

  // phase state registers track the counters
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_hph <= PH_VIS;
      r_vph <= PH_VIS;
    end else begin
      r_hph <= w_hph_nxt;
      r_vph <= w_vph_nxt;
    end
  end

  // phase next-state: vertical steps only on line wrap
  always_comb begin
    w_hph_nxt = r_hph;
    w_vph_nxt = r_vph;
    if (!bus.EN) begin
      w_hph_nxt = PH_VIS;
      w_vph_nxt = PH_VIS;
    end else begin
      w_hph_nxt = next_phase(r_hph, int'(r_col),
                    H_VIS, H_FP, H_SW, H_TOT);
      if (w_hwrap)
        w_vph_nxt = next_phase(r_vph, int'(r_row),
                      V_VIS, V_FP, V_SW, V_TOT);
    end
  end

  assign w_raw = {
    r_hph == PH_SYNC,
    r_vph == PH_SYNC,
    (r_hph == PH_VIS) && (r_vph == PH_VIS)
  };

  vga_delay #(.W(3), .D(1)) u_stage1 (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_clr   (!bus.EN),
    .i_d     (w_raw),
    .o_q     (w_s1)
  );

  // source colour arrives with stage 1; blank it outside DE
  assign w_s2_in = {
    w_s1,
    w_s1[0] ? {bus.R_IN, bus.G_IN, bus.B_IN} : 24'h0
  };

  vga_delay #(.W(27), .D(1)) u_stage2 (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_clr   (!bus.EN),
    .i_d     (w_s2_in),
    .o_q     (w_s2)
  );

  assign bus.COL        = r_col;
  assign bus.ROW        = r_row;
  assign bus.HSYNC      = w_s2[26];
  assign bus.VSYNC      = w_s2[25];
  assign bus.DE         = w_s2[24];
  assign bus.R          = w_s2[23:16];
  assign bus.G          = w_s2[15:8];
  assign bus.B          = w_s2[7:0];
  assign bus.FRAME_TICK = r_tick;
  assign bus.MODE       = r_mode;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl on a scaled-down
// raster, with a position-arithmetic model.
module tb_vga_timing_ctrl;

  localparam int HV = 16, HF = 2, HS = 4, HB = 3;
  localparam int VV = 6,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int MP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  vga_timing_ctrl_if bus();

  vga_timing_ctrl #(
    .H_VIS(HV), .H_FP(HF), .H_SW(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SW(VS), .V_BP(VB),
    .MODE_PERIOD(MP)
  ) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d",
               nm, $time, act, exp);
    end
  endtask

  // pattern source: G/B change every cycle
  initial begin
    bus.G_IN = 8'h00;
    bus.B_IN = 8'h80;
    forever begin
      @(posedge clk);
      #1;
      bus.G_IN = bus.G_IN + 8'd7;
      bus.B_IN = bus.B_IN - 8'd3;
    end
  end

  // model: scan position p in 0..FT-1, two-cycle history
  int          mp = 0;
  int          p1 = 0, p2 = 0;
  bit          e1 = 0, e2 = 0;
  logic [23:0] rin1 = '0;
  bit          mtick = 0;
  int          mfc = 0;
  int          mmode = 0;

  initial forever begin
    int h, v;
    bit ok2, ehs, evs, ede, cur, nt;
    logic [23:0] ergb;
    @(negedge clk);
    if (!rst_n) begin
      mp = 0; e1 = 0; e2 = 0;
      mtick = 0; mfc = 0; mmode = 0;
    end
    h   = p2 % HT;
    v   = p2 / HT;
    ok2 = e1 && e2;
    ehs = ok2 && h >= HV + HF && h < HV + HF + HS;
    evs = ok2 && v >= VV + VF && v < VV + VF + VS;
    ede = ok2 && h < HV && v < VV;
    ergb = ede ? rin1 : 24'h0;
    chk("col",   bus.COL,   mp % HT);
    chk("row",   bus.ROW,   mp / HT);
    chk("hsync", bus.HSYNC, ehs);
    chk("vsync", bus.VSYNC, evs);
    chk("de",    bus.DE,    ede);
    chk("r",     bus.R,     ergb[23:16]);
    chk("g",     bus.G,     ergb[15:8]);
    chk("b",     bus.B,     ergb[7:0]);
    chk("tick",  bus.FRAME_TICK, mtick);
    chk("mode",  bus.MODE,  mmode);
    cur = rst_n && bus.EN;
    nt  = cur && (mp == FT - 1);
    if (nt && !bus.MODE_HOLD) begin
      mfc++;
      if (mfc == MP) begin
        mfc = 0;
        mmode = (mmode + 1) % 4;
      end
    end
    e2 = e1; p2 = p1;
    e1 = cur; p1 = mp;
    rin1 = {bus.R_IN, bus.G_IN, bus.B_IN};
    mtick = nt;
    mp = cur ? (mp + 1) % FT : 0;
  end

  int n_cyc, n_hs, n_vs, n_de, n_rnz, n_roff;

  // advance to next FRAME_TICK, gathering output statistics
  task automatic run_to_tick();
    n_cyc = 0; n_hs = 0; n_vs = 0;
    n_de = 0; n_rnz = 0; n_roff = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      @(posedge clk);
      #1;
      n_cyc++;
      if (bus.FRAME_TICK) return;
      n_hs += int'(bus.HSYNC);
      n_vs += int'(bus.VSYNC);
      n_de += int'(bus.DE);
      if (bus.R != 8'h00) n_rnz++;
      if (bus.DE != (bus.R == 8'hFE)) n_roff++;
    end
    chk("tick_timeout", 0, 1);
  endtask

  task automatic wait_pos(input int c, input int r);
    for (int i = 0; i < 2 * FT; i++) begin
      @(posedge clk);
      #1;
      if (bus.COL == c && bus.ROW == r) return;
    end
    chk("pos_timeout", 0, 1);
  endtask

  int exp_mode [8] = '{0, 1, 1, 2, 2, 3, 3, 0};
  int nticks;

  initial begin
    bus.EN = 1'b0;
    bus.MODE_HOLD = 1'b0;
    bus.R_IN = 8'hFE;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col",  bus.COL, 0);
    chk("rst_row",  bus.ROW, 0);
    chk("rst_mode", bus.MODE, 0);
    chk("rst_de",   bus.DE, 0);
    rst_n = 1'b1;
    bus.EN = 1'b1;
    @(posedge clk);
    #1;
    chk("col_first_step", bus.COL, 1);
    repeat (HT - 1) @(posedge clk);
    #1;
    chk("col_line_wrap", bus.COL, 0);
    chk("row_line_inc",  bus.ROW, 1);

    for (int i = 0; i < 8; i++) begin
      run_to_tick();
      chk("mode_seq", bus.MODE, exp_mode[i]);
      if (i == 1) begin
        chk("frame_len",   n_cyc, 275);
        chk("hsync_count", n_hs, 44);
        chk("vsync_count", n_vs, 50);
        chk("de_count",    n_de, 96);
        chk("r_nz_count",  n_rnz, 96);
        chk("r_vs_de",     n_roff, 0);
      end
    end

    bus.MODE_HOLD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_to_tick();
      chk("mode_hold", bus.MODE, 0);
    end
    bus.MODE_HOLD = 1'b0;
    run_to_tick();
    run_to_tick();
    chk("mode_after_hold", bus.MODE, 1);

    wait_pos(10, 3);
    bus.EN = 1'b0;
    nticks = 0;
    @(posedge clk);
    #1;
    chk("en_off_col", bus.COL, 0);
    chk("en_off_row", bus.ROW, 0);
    @(posedge clk);
    #1;
    chk("en_off_out",
        {bus.HSYNC, bus.VSYNC, bus.DE, bus.R}, 0);
    for (int i = 0; i < 8; i++) begin
      nticks += int'(bus.FRAME_TICK);
      @(posedge clk);
      #1;
    end
    bus.EN = 1'b1;
    chk("en_off_ticks", nticks, 0);
    chk("en_on_col0", bus.COL, 0);
    @(posedge clk);
    #1;
    chk("en_on_col1", bus.COL, 1);
    chk("en_on_tick", bus.FRAME_TICK, 0);

    wait_pos(19, 8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_col",  bus.COL, 0);
    chk("arst_row",  bus.ROW, 0);
    chk("arst_sync", {bus.HSYNC, bus.VSYNC}, 0);
    chk("arst_mode", bus.MODE, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_restart_col", bus.COL, 1);
    chk("arst_restart_row", bus.ROW, 0);
    repeat (30) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
